// File: rtl/vga_sync_out_if.sv
// Pixel-rate bus between the colour-space converter stage and the VGA/YPbPr pin driver.
// The master drives the converted pixel stream and mode bits; the slave returns the registered pin values.
interface vga_sync_out_if;
  logic        ce_pix;
  logic [23:0] din;
  logic        hs_in;
  logic        vs_in;
  logic        de_in;
  logic        ypbpr_en;
  logic        csync_en;
  logic [23:0] dout;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;

  modport master (
    output ce_pix, din, hs_in, vs_in, de_in, ypbpr_en, csync_en,
    input  dout, hs_out, vs_out, de_out
  );

  modport slave (
    input  ce_pix, din, hs_in, vs_in, de_in, ypbpr_en, csync_en,
    output dout, hs_out, vs_out, de_out
  );
endinterface

// File: rtl/vga_sync_out.sv
// Output register stage for the analog video pins: blanks colour outside active video and
// optionally replaces HS with a serrated composite sync derived from measured line timing.
module vga_sync_out #(
  parameter int          CW          = 12,
  parameter logic [23:0] BLANK_YPBPR = {8'd128, 8'd16, 8'd128}
) (
  input  logic          clk_sys,
  input  logic          reset,
  vga_sync_out_if.slave bus
);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] line_len_q, line_len_d;
  logic [CW-1:0] hs_width_q, hs_width_d;
  logic          hs_prev_q, hs_prev_d;
  logic          rise_seen_q, rise_seen_d;
  logic          line_ok_q, line_ok_d;
  logic          width_ok_q, width_ok_d;
  logic [23:0]   dout_q, dout_d;
  logic          de_out_q, de_out_d;
  logic          hs_out_q, hs_out_d;
  logic          vs_out_q, vs_out_d;

  logic          hs_rise;
  logic          hs_fall;
  logic          meas_valid;
  logic          cs;
  logic [CW-1:0] h_cnt_next;
  logic [CW-1:0] gap_start;

  // Serration is only trusted once a full rise-to-rise line and a sync width have been
  // captured since reset; a saturated line wraps line_len to 0 and falls back as well.
  always_comb begin
    hs_rise = bus.hs_in & ~hs_prev_q;
    hs_fall = ~bus.hs_in & hs_prev_q;

    if (hs_rise) begin
      h_cnt_next = '0;
    end else if (&h_cnt_q) begin
      h_cnt_next = h_cnt_q;
    end else begin
      h_cnt_next = h_cnt_q + 1'b1;
    end

    meas_valid = line_ok_q & width_ok_q & (line_len_q != '0) & (hs_width_q < line_len_q);
    gap_start  = line_len_q - hs_width_q;

    if (!bus.vs_in) begin
      cs = bus.hs_in;
    end else if (meas_valid) begin
      cs = (h_cnt_next < gap_start);
    end else begin
      cs = bus.hs_in ^ bus.vs_in;
    end
  end

  always_comb begin
    h_cnt_d     = h_cnt_q;
    line_len_d  = line_len_q;
    hs_width_d  = hs_width_q;
    hs_prev_d   = hs_prev_q;
    rise_seen_d = rise_seen_q;
    line_ok_d   = line_ok_q;
    width_ok_d  = width_ok_q;
    dout_d      = dout_q;
    de_out_d    = de_out_q;
    hs_out_d    = hs_out_q;
    vs_out_d    = vs_out_q;

    if (bus.ce_pix) begin
      h_cnt_d   = h_cnt_next;
      hs_prev_d = bus.hs_in;

      if (hs_rise) begin
        line_len_d  = h_cnt_q + 1'b1;
        rise_seen_d = 1'b1;
        line_ok_d   = rise_seen_q;
      end

      if (hs_fall) begin
        hs_width_d = h_cnt_q + 1'b1;
        width_ok_d = rise_seen_q;
      end

      if (bus.de_in) begin
        dout_d = bus.din;
      end else begin
        dout_d = bus.ypbpr_en ? BLANK_YPBPR : 24'h0;
      end

      de_out_d = bus.de_in;
      hs_out_d = bus.csync_en ? ~cs : ~bus.hs_in;
      vs_out_d = bus.csync_en ? 1'b1 : ~bus.vs_in;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      h_cnt_q     <= '0;
      line_len_q  <= '0;
      hs_width_q  <= '0;
      hs_prev_q   <= 1'b0;
      rise_seen_q <= 1'b0;
      line_ok_q   <= 1'b0;
      width_ok_q  <= 1'b0;
      dout_q      <= 24'h0;
      de_out_q    <= 1'b0;
      hs_out_q    <= 1'b1;
      vs_out_q    <= 1'b1;
    end else begin
      h_cnt_q     <= h_cnt_d;
      line_len_q  <= line_len_d;
      hs_width_q  <= hs_width_d;
      hs_prev_q   <= hs_prev_d;
      rise_seen_q <= rise_seen_d;
      line_ok_q   <= line_ok_d;
      width_ok_q  <= width_ok_d;
      dout_q      <= dout_d;
      de_out_q    <= de_out_d;
      hs_out_q    <= hs_out_d;
      vs_out_q    <= vs_out_d;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.de_out = de_out_q;
  assign bus.hs_out = hs_out_q;
  assign bus.vs_out = vs_out_q;

endmodule
